// File: rtl/stream_timestamp_inserter_if.sv
// Valid/ready word stream used on both sides of the timestamp inserter.
// The master drives valid and data. The slave drives ready.
interface stream_timestamp_inserter_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  valid;
    logic                  ready;
    logic [DATA_WIDTH-1:0] data;

    modport master (output valid, output data, input ready);
    modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/stream_timestamp_inserter.sv
// Small first-word-fall-through buffer between the readout arbiter and the
// BRAM output FIFO. When enabled, it periodically injects a timestamp marker
// word ({TS_HEADER, TIMESTAMP[27:0]}) into the stream. A pending timestamp
// has priority over upstream data.
module stream_timestamp_inserter #(
    parameter int         DEPTH        = 4,
    parameter logic [3:0] TS_HEADER    = 4'b0101,
    parameter int         PERIOD_WIDTH = 16
) (
    input  logic                          BUS_CLK,
    input  logic                          BUS_RST_N,
    input  logic                          ENABLE,
    input  logic [PERIOD_WIDTH-1:0]       PERIOD,
    input  logic [31:0]                   TIMESTAMP,
    stream_timestamp_inserter_if.slave    upstream,
    stream_timestamp_inserter_if.master   downstream,
    output logic [31:0]                   WORD_COUNT,
    output logic [PERIOD_WIDTH-1:0]       TS_COUNT,
    output logic                          OVERRUN
);

    localparam int PTR_WIDTH   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int COUNT_WIDTH = $clog2(DEPTH) + 1;

    localparam logic [COUNT_WIDTH-1:0]  FULL_COUNT = COUNT_WIDTH'(DEPTH);
    localparam logic [PERIOD_WIDTH-1:0] PERIOD_ONE = PERIOD_WIDTH'(1);

    logic [31:0]             mem [DEPTH];
    logic [PTR_WIDTH-1:0]    rd_ptr;
    logic [PTR_WIDTH-1:0]    wr_ptr;
    logic [COUNT_WIDTH-1:0]  count;

    logic [PERIOD_WIDTH-1:0] period_cnt;
    logic                    ts_pending;
    logic [27:0]             ts_reg;

    logic                    has_room;
    logic                    period_active;
    logic                    expire;
    logic                    insert;
    logic                    push;
    logic                    pop;
    logic                    write;
    logic [31:0]             write_data;

    // Head of the buffer is always visible downstream (fall-through).
    // Upstream is refused while a timestamp waits, so the marker wins
    // the next free slot.
    assign downstream.valid = (count != '0);
    assign downstream.data  = mem[rd_ptr];
    assign upstream.ready   = BUS_RST_N & has_room & ~ts_pending;

    // Handshake decode and write-port selection between data and timestamp.
    always_comb begin
        has_room      = (count < FULL_COUNT);
        push          = upstream.valid & upstream.ready;
        insert        = ts_pending & has_room;
        write         = push | insert;
        write_data    = insert ? {TS_HEADER, ts_reg} : upstream.data;
        pop           = downstream.valid & downstream.ready;
        period_active = ENABLE & (PERIOD != '0);
        expire        = period_active & (period_cnt == (PERIOD - PERIOD_ONE));
    end

    // Storage array. Contents after reset are don't-care, so it has no reset.
    always_ff @(posedge BUS_CLK) begin
        if (write) begin
            mem[wr_ptr] <= write_data;
        end
    end

    // Read/write pointers and occupancy. Pointers wrap naturally at DEPTH.
    always_ff @(posedge BUS_CLK or negedge BUS_RST_N) begin
        if (!BUS_RST_N) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (write) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (write && !pop) begin
                count <= count + 1'b1;
            end else if (!write && pop) begin
                count <= count - 1'b1;
            end
        end
    end

    // Period counter and pending timestamp. A new expiry overwrites ts_reg,
    // so at most one marker is queued and it carries the latest time.
    always_ff @(posedge BUS_CLK or negedge BUS_RST_N) begin
        if (!BUS_RST_N) begin
            period_cnt <= '0;
            ts_pending <= 1'b0;
            ts_reg     <= '0;
        end else if (!period_active) begin
            period_cnt <= '0;
            ts_pending <= 1'b0;
        end else if (expire) begin
            period_cnt <= '0;
            ts_pending <= 1'b1;
            ts_reg     <= TIMESTAMP[27:0];
        end else begin
            period_cnt <= period_cnt + 1'b1;
            if (insert) begin
                ts_pending <= 1'b0;
            end
        end
    end

    // Sticky overrun: an expiry found the previous marker still waiting.
    // An expiry in the same cycle as an insertion is not an overrun.
    always_ff @(posedge BUS_CLK or negedge BUS_RST_N) begin
        if (!BUS_RST_N) begin
            OVERRUN <= 1'b0;
        end else if (!ENABLE) begin
            OVERRUN <= 1'b0;
        end else if (expire && ts_pending && !insert) begin
            OVERRUN <= 1'b1;
        end
    end

    // Free-running statistics counters. Both wrap.
    always_ff @(posedge BUS_CLK or negedge BUS_RST_N) begin
        if (!BUS_RST_N) begin
            WORD_COUNT <= '0;
            TS_COUNT   <= '0;
        end else begin
            if (pop) begin
                WORD_COUNT <= WORD_COUNT + 32'd1;
            end
            if (insert) begin
                TS_COUNT <= TS_COUNT + 1'b1;
            end
        end
    end

endmodule
